// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart msip and
// mtimecmp, native-bus slave with registered read data and one-cycle ready pulse.
module clint_mh #(
  parameter int unsigned NHARTS = 1,
  parameter logic [31:0] BASE   = 32'h1100_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic [31:0]       addr,
  input  logic [3:0]        wmask,
  input  logic [31:0]       wdata,
  input  logic [15:0]       div,
  output logic [31:0]       rdata,
  output logic              is_valid,
  output logic              ready,
  output logic [NHARTS-1:0] msip_irq,
  output logic [NHARTS-1:0] mtip_irq
);

  localparam int unsigned HW = 4;

  logic              win_hit;
  logic              msip_sel;
  logic              cmp_sel;
  logic              mtime_sel;
  logic [HW-1:0]     msip_idx;
  logic [HW-1:0]     cmp_idx;
  logic              hi_half;
  logic              accept;
  logic              wr;
  logic              tick;
  logic [15:0]       tick_cnt;
  logic [63:0]       mtime;
  logic [63:0]       mtimecmp [NHARTS];
  logic [NHARTS-1:0] msip;
  logic [31:0]       rd_val;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  m);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode inside the 64 KiB window; harts beyond NHARTS stay unmapped
  assign win_hit   = (addr[31:16] == BASE[31:16]) && (addr[1:0] == 2'b00);
  assign msip_idx  = addr[5:2];
  assign cmp_idx   = addr[6:3];
  assign hi_half   = addr[2];
  assign msip_sel  = win_hit && (addr[15:6] == 10'd0) && (32'(msip_idx) < NHARTS);
  assign cmp_sel   = win_hit && (addr[15:7] == 9'h080) && (32'(cmp_idx) < NHARTS);
  assign mtime_sel = win_hit && (addr[15:3] == 13'h17FF);

  assign is_valid = valid && (msip_sel || cmp_sel || mtime_sel);
  assign accept   = is_valid && !ready;
  assign wr       = accept && (wmask != 4'd0);
  assign tick     = (div != 16'd0) && (tick_cnt >= (div - 16'd1));
  assign msip_irq = msip;

  // Pre-write read value of the addressed register
  always_comb begin
    rd_val = 32'd0;
    for (int h = 0; h < NHARTS; h++) begin
      if (msip_sel && (msip_idx == HW'(h))) rd_val = {31'd0, msip[h]};
      if (cmp_sel && (cmp_idx == HW'(h)))
        rd_val = hi_half ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
    if (mtime_sel) rd_val = hi_half ? mtime[63:32] : mtime[31:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready    <= 1'b0;
      rdata    <= 32'd0;
      tick_cnt <= 16'd0;
      mtime    <= 64'd0;
      msip     <= '0;
      mtip_irq <= '0;
      for (int h = 0; h < NHARTS; h++) mtimecmp[h] <= '1;
    end else begin
      ready    <= accept;
      rdata    <= (accept && !wr) ? rd_val : 32'd0;
      tick_cnt <= (tick || (div == 16'd0)) ? 16'd0 : tick_cnt + 16'd1;

      // A bus write to either mtime half suppresses that cycle's increment
      if (wr && mtime_sel) begin
        if (hi_half) mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wmask);
        else         mtime[31:0]  <= merge_bytes(mtime[31:0], wdata, wmask);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      for (int h = 0; h < NHARTS; h++) begin
        if (wr && msip_sel && (msip_idx == HW'(h)) && wmask[0]) msip[h] <= wdata[0];
        if (wr && cmp_sel && (cmp_idx == HW'(h))) begin
          if (hi_half) mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wmask);
          else         mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], wdata, wmask);
        end
        mtip_irq[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

endmodule

// File: tb/tb_clint_mh.sv
// Scoreboard bench for clint_mh (4 harts): directed scenarios plus random bus traffic
// checked against a cycle-level behavioural model of the CLINT register map.
module tb_clint_mh;

  localparam int unsigned N     = 4;
  localparam logic [31:0] BASE  = 32'h1100_0000;
  localparam logic [31:0] MT_LO = BASE + 32'h0000_BFF8;
  localparam logic [31:0] MT_HI = BASE + 32'h0000_BFFC;

  logic          clk;
  logic          resetn;
  logic          valid;
  logic [31:0]   addr;
  logic [3:0]    wmask;
  logic [31:0]   wdata;
  logic [15:0]   div;
  logic [31:0]   rdata;
  logic          is_valid;
  logic          ready;
  logic [N-1:0]  msip_irq;
  logic [N-1:0]  mtip_irq;

  int checks = 0;
  int errors = 0;

  clint_mh #(.NHARTS(N), .BASE(BASE)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (valid),
    .addr     (addr),
    .wmask    (wmask),
    .wdata    (wdata),
    .div      (div),
    .rdata    (rdata),
    .is_valid (is_valid),
    .ready    (ready),
    .msip_irq (msip_irq),
    .mtip_irq (mtip_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0]  m_mtime;
  logic [63:0]  m_cmp [N];
  logic [N-1:0] m_msip;
  logic [N-1:0] m_mtip;
  int unsigned  m_phase;
  logic         m_ready;
  logic [31:0]  exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] msip_addr(input int h);
    return BASE + 32'(4 * h);
  endfunction

  function automatic logic [31:0] cmp_addr(input int h, input int hi);
    return BASE + 32'h0000_4000 + 32'(8 * h) + ((hi != 0) ? 32'd4 : 32'd0);
  endfunction

  // kind: 0 unmapped, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
  function automatic void decode(input logic [31:0] a, output int kind, output int hh);
    longint unsigned off;
    kind = 0;
    hh   = 0;
    if (a < BASE) return;
    off = 64'(a) - 64'(BASE);
    if (off >= 64'd65536 || (off % 4) != 0) return;
    if (off < 64'(4 * N)) begin
      kind = 1;
      hh   = int'(off / 4);
    end else if (off >= 64'h4000 && off < 64'h4000 + 64'(8 * N)) begin
      hh   = int'((off - 64'h4000) / 8);
      kind = ((off % 8) == 0) ? 2 : 3;
    end else if (off == 64'hBFF8) begin
      kind = 4;
    end else if (off == 64'hBFFC) begin
      kind = 5;
    end
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Model: advances once per clock edge from the inputs seen before the edge
  initial begin : model
    int          k;
    int          hh;
    logic        acc;
    logic        tk;
    logic        mt_wr;
    logic [N-1:0] nm;
    logic [31:0] rv;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_mtime = 64'd0;
        for (int i = 0; i < N; i++) m_cmp[i] = '1;
        m_msip  = '0;
        m_mtip  = '0;
        m_phase = 0;
        m_ready = 1'b0;
        exp_q.delete();
      end else begin
        decode(addr, k, hh);
        acc = valid && (k != 0) && !m_ready;
        for (int i = 0; i < N; i++) nm[i] = (m_mtime >= m_cmp[i]);
        tk = (div != 16'd0) && ((m_phase + 1) >= 32'(div));
        mt_wr = 1'b0;
        if (acc) begin
          case (k)
            1:       rv = {31'd0, m_msip[hh]};
            2:       rv = m_cmp[hh][31:0];
            3:       rv = m_cmp[hh][63:32];
            4:       rv = m_mtime[31:0];
            default: rv = m_mtime[63:32];
          endcase
          exp_q.push_back((wmask == 4'd0) ? rv : 32'd0);
          if (wmask != 4'd0) begin
            case (k)
              1:       if (wmask[0]) m_msip[hh] = wdata[0];
              2:       m_cmp[hh][31:0]  = merge32(m_cmp[hh][31:0], wdata, wmask);
              3:       m_cmp[hh][63:32] = merge32(m_cmp[hh][63:32], wdata, wmask);
              4:       begin m_mtime[31:0]  = merge32(m_mtime[31:0], wdata, wmask);  mt_wr = 1'b1; end
              default: begin m_mtime[63:32] = merge32(m_mtime[63:32], wdata, wmask); mt_wr = 1'b1; end
            endcase
          end
        end
        if (tk && !mt_wr) m_mtime = m_mtime + 64'd1;
        m_phase = (tk || (div == 16'd0)) ? 0 : m_phase + 1;
        m_ready = acc;
        m_mtip  = nm;
      end
    end
  end

  // Monitor: compares DUT against the model and pops read data on every ready pulse
  initial begin : monitor
    int          k;
    int          hh;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (resetn === 1'b1) begin
        chk("ready", 64'(ready), 64'(m_ready));
        if (ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("rdata_unexpected", 64'(rdata), 64'hDEAD_0000_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", 64'(rdata), 64'(e));
          end
        end
        chk("mtip_irq", 64'(mtip_irq), 64'(m_mtip));
        chk("msip_irq", 64'(msip_irq), 64'(m_msip));
        decode(addr, k, hh);
        chk("is_valid", 64'(is_valid), 64'(valid && (k != 0)));
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    int n;
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    wmask = m;
    wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 8);
    chk("access_ready", 64'(ready), 64'd1);
    valid = 1'b0;
    wmask = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a);
    access(a, 4'd0, 32'd0);
  endtask

  task automatic unmapped(input logic [31:0] a);
    int seen;
    seen = 0;
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    wmask = 4'd0;
    repeat (4) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    chk("unmapped_ready", 64'(seen), 64'd0);
    valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int          n;
    int          cnt;
    logic [31:0] prev;
    logic        have_prev;
    resetn = 1'b0;
    valid  = 1'b0;
    addr   = 32'd0;
    wmask  = 4'd0;
    wdata  = 32'd0;
    div    = 16'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mtip",  64'(mtip_irq), 64'd0);
    chk("rst_msip",  64'(msip_irq), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    rd(cmp_addr(0, 0));
    rd(cmp_addr(3, 1));

    // Prescaler: div=3, frozen, div=1, carry from lo into hi
    div = 16'd3;
    repeat (12) @(negedge clk);
    rd(MT_LO);
    div = 16'd0;
    rd(MT_LO);
    repeat (10) @(negedge clk);
    rd(MT_LO);
    div = 16'd1;
    access(MT_LO, 4'hF, 32'hFFFF_FFF8);
    repeat (12) @(negedge clk);
    rd(MT_LO);
    rd(MT_HI);

    // 64-bit wrap
    access(MT_HI, 4'hF, 32'hFFFF_FFFF);
    access(MT_LO, 4'hF, 32'hFFFF_FFFE);
    rd(MT_LO);
    rd(MT_HI);

    // Timer IRQ on hart 2
    access(MT_HI, 4'hF, 32'd0);
    access(MT_LO, 4'hF, 32'd0);
    access(cmp_addr(2, 1), 4'hF, 32'd0);
    access(cmp_addr(2, 0), 4'hF, 32'h20);
    n = 0;
    while (mtip_irq !== 4'b0100 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mtip_assert", 64'(mtip_irq), 64'h4);
    access(cmp_addr(2, 1), 4'hF, 32'd1);
    @(negedge clk);
    #1;
    chk("mtip2_drop", 64'(mtip_irq[2]), 64'd0);

    // msip
    access(msip_addr(2), 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    chk("msip_set", 64'(msip_irq), 64'h4);
    rd(msip_addr(2));
    unmapped(msip_addr(4));
    unmapped(cmp_addr(4, 0));

    // mtime partial write on a tick cycle
    div = 16'd1;
    access(MT_LO, 4'b0011, 32'hABCD_1234);
    rd(MT_LO);
    rd(MT_HI);

    // Held valid: one access every two cycles
    @(negedge clk);
    valid = 1'b1;
    addr  = MT_LO;
    wmask = 4'd0;
    cnt = 0;
    have_prev = 1'b0;
    prev = 32'd0;
    repeat (6) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        cnt++;
        if (have_prev) chk("held_monotonic", 64'(rdata >= prev), 64'd1);
        prev = rdata;
        have_prev = 1'b1;
      end
    end
    valid = 1'b0;
    chk("held_ready_cnt", 64'(cnt), 64'd3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int          k;
      int          hh;
      int          sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = msip_addr(int'($urandom_range(0, 5)));
        1, 2:    a = cmp_addr(int'($urandom_range(0, 4)), int'($urandom_range(0, 1)));
        3:       a = MT_LO;
        4:       a = MT_HI;
        5:       a = $urandom;
        6:       a = MT_LO + 32'd1;
        default: a = cmp_addr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1)));
      endcase
      if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 4));
      decode(a, k, hh);
      if (k != 0) begin
        if ($urandom_range(0, 1) == 0) access(a, 4'd0, 32'd0);
        else access(a, 4'($urandom_range(1, 15)), $urandom);
      end else begin
        unmapped(a);
      end
    end

    // Reset in the middle of an access with mtime running
    div = 16'd1;
    access(msip_addr(1), 4'h1, 32'd1);
    access(cmp_addr(0, 1), 4'hF, 32'd0);
    access(cmp_addr(0, 0), 4'hF, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_mtip0", 64'(mtip_irq[0]), 64'd1);
    @(negedge clk);
    valid = 1'b1;
    addr  = MT_LO;
    wmask = 4'd0;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_rdata", 64'(rdata), 64'd0);
    chk("async_rst_mtip",  64'(mtip_irq), 64'd0);
    chk("async_rst_msip",  64'(msip_irq), 64'd0);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_mtip", 64'(mtip_irq), 64'd0);
    end
    rd(cmp_addr(0, 0));
    rd(cmp_addr(0, 1));
    rd(MT_LO);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
